// File: rtl/servo_cmd_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : servo_cmd_encoder                                                |
// | Purpose : push-button front end for the servo PWM stage; debounces        |
// |           L/N/R, issues paced one-hot commands on DOUT.                    |
// | Options : AUTOREPEAT_EN enables held-button auto-repeat for L and R.       |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module servo_cmd_encoder #(
`ifdef AUTOREPEAT_EN
  parameter int REPEAT_DELAY   = 64,
  parameter int REPEAT_TICKS   = 16,
`endif
  parameter int DEBOUNCE_TICKS = 16,
  parameter int HOLDOFF_TICKS  = 4
) (
  input  logic       SCLK,
  input  logic       RESET,
  input  logic       BTN_L,
  input  logic       BTN_N,
  input  logic       BTN_R,
  output logic [2:0] DOUT,
  output logic       BUSY,
  output logic       OVERRUN
);

  localparam int              DB_W      = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DB_W-1:0] DB_MAX    = DB_W'(DEBOUNCE_TICKS);
  localparam int              T_W       = $clog2(HOLDOFF_TICKS + 2);
  localparam logic [T_W-1:0]  HOLD_LOAD = T_W'(HOLDOFF_TICKS - 1);
  localparam logic [T_W-1:0]  ISSUE_LOAD = T_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  // Bit order everywhere matches the command encoding: [2]=L, [1]=N, [0]=R.
  logic [2:0] sync1_q, sync2_q, deb_prev_q;
  logic [2:0] deb_lvl;
  logic [2:0] press_req;
  logic [2:0] new_req;

  always_ff @(posedge SCLK) begin
    if (RESET) begin
      sync1_q    <= 3'b000;
      sync2_q    <= 3'b000;
      deb_prev_q <= 3'b000;
    end else begin
      sync1_q    <= {BTN_L, BTN_N, BTN_R};
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_lvl;
    end
  end

  for (genvar b = 0; b < 3; b++) begin : g_btn
    logic [DB_W-1:0] cnt_q;
    logic            deb_bit_q;

    always_ff @(posedge SCLK) begin
      if (RESET) begin
        cnt_q     <= '0;
        deb_bit_q <= 1'b0;
      end else if (sync2_q[b] == deb_bit_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DB_MAX) begin
        cnt_q     <= '0;
        deb_bit_q <= sync2_q[b];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign deb_lvl[b] = deb_bit_q;
  end

  assign press_req = deb_lvl & ~deb_prev_q;

`ifdef AUTOREPEAT_EN
  localparam int              RP_W      = $clog2(REPEAT_DELAY + 1);
  localparam logic [RP_W-1:0] RP_DELAY  = RP_W'(REPEAT_DELAY);
  localparam logic [RP_W-1:0] RP_RELOAD = RP_W'(REPEAT_DELAY - REPEAT_TICKS + 1);

  logic [2:0] rpt_req;

  // Only L (bit 2) and R (bit 0) repeat; counter measures cycles since the press edge.
  for (genvar i = 0; i < 2; i++) begin : g_rpt
    localparam int BI = 2 * i;
    logic [RP_W-1:0] rcnt_q;

    always_ff @(posedge SCLK) begin
      if (RESET || !deb_lvl[BI]) begin
        rcnt_q <= '0;
      end else if (rcnt_q == RP_DELAY) begin
        rcnt_q <= RP_RELOAD;
      end else begin
        rcnt_q <= rcnt_q + 1'b1;
      end
    end

    assign rpt_req[BI] = deb_lvl[BI] && (rcnt_q == RP_DELAY);
  end

  assign rpt_req[1] = 1'b0;
  assign new_req    = press_req | rpt_req;
`else
  assign new_req = press_req;
`endif

  function automatic logic [2:0] pick_top(input logic [2:0] v);
    logic [2:0] r;
    r = 3'b000;
    if (v[2])      r = 3'b100;
    else if (v[1]) r = 3'b010;
    else if (v[0]) r = 3'b001;
    return r;
  endfunction

  logic [2:0] req_first, req_second;
  logic [1:0] n_req;

  assign req_first  = pick_top(new_req);
  assign req_second = pick_top(new_req & ~req_first);
  assign n_req      = {1'b0, new_req[0]} + {1'b0, new_req[1]} + {1'b0, new_req[2]};

  state_t         state_q, state_d;
  logic [T_W-1:0] tmr_q, tmr_d;
  logic [2:0]     dout_q, dout_d;
  logic [2:0]     pend_q, pend_d;
  logic           ovr_q, ovr_d;
  logic           can_issue;

  always_ff @(posedge SCLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      dout_q  <= 3'b000;
      pend_q  <= 3'b000;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      dout_q  <= dout_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    dout_d    = dout_q;
    pend_d    = pend_q;
    ovr_d     = 1'b0;
    can_issue = 1'b0;

    case (state_q)
      S_IDLE:  can_issue = 1'b1;
      S_ISSUE: begin
        if (tmr_q == '0) begin
          state_d = S_HOLD;
          tmr_d   = HOLD_LOAD;
          dout_d  = 3'b000;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      // The last holdoff cycle makes the idle decision itself so back-to-back
      // commands start exactly 2+HOLDOFF_TICKS cycles apart.
      S_HOLD: begin
        if (tmr_q == '0) can_issue = 1'b1;
        else             tmr_d     = tmr_q - 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        tmr_d   = '0;
        dout_d  = 3'b000;
      end
    endcase

    if (can_issue) begin
      state_d = S_IDLE;
      dout_d  = 3'b000;
      if (pend_q != 3'b000) begin
        state_d = S_ISSUE;
        tmr_d   = ISSUE_LOAD;
        dout_d  = pend_q;
        pend_d  = req_first;
        ovr_d   = (n_req >= 2'd2);
      end else if (new_req != 3'b000) begin
        state_d = S_ISSUE;
        tmr_d   = ISSUE_LOAD;
        dout_d  = req_first;
        pend_d  = req_second;
        ovr_d   = (n_req == 2'd3);
      end
    end else if ((state_q == S_ISSUE || state_q == S_HOLD) && new_req != 3'b000) begin
      pend_d = req_first;
      ovr_d  = (pend_q != 3'b000) || (n_req >= 2'd2);
    end
  end

  assign DOUT    = dout_q;
  assign BUSY    = (state_q == S_ISSUE) || (state_q == S_HOLD);
  assign OVERRUN = ovr_q;

endmodule
`default_nettype wire
